point_dma_w_channel: RTL

Write-direction counterpart of the point DMA read channel. Drains NTT result points from the coarse/fine point FIFO and writes them to one HBM pseudo-channel over AXI4 (AW/W/B) in fixed-length INCR bursts. FIFO occupancy is exchanged with the producer through gray-coded coarse pointers. One instance per HBM port, between the NTT output FIFO and the HBM crossbar.

---
 rtl/point_dma_w_channel.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/point_dma_w_channel.sv
// point_dma_w_channel: drains NTT result points from the coarse/fine point FIFO into AXI4 INCR write bursts
// Ports: clk_i/rst_i (async, active-high); start_i/release_i/done_o/err_o job control;
//    re_o/raddr_o/rdata_i FIFO read side (1-cycle read latency); wcoarse_i/rcoarse_o gray coarse pointers;
//    ctrl_addr_offset job base byte address; m_axi_aw*/w*/b* AXI4 write master.
// Option: define POINT_DMA_W_BRESP_CHECK_EN to latch non-OKAY write responses onto err_o.
module point_dma_w_channel #(
   parameter int ID                 = 0,
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 256,
   parameter int BURST_LEN          = 16,
   parameter int COARSE_DEPTH       = 4,
   parameter int COARSE_W           = 3,
   parameter int N_BEATS            = 1024
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        start_i,
   input  logic                                        release_i,
   output logic                                        done_o,
   output logic                                        err_o,
   output logic                                        re_o,
   output logic [$clog2(COARSE_DEPTH*BURST_LEN)-1:0]   raddr_o,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]               rdata_i,
   input  logic [COARSE_W-1:0]                         wcoarse_i,
   output logic [COARSE_W-1:0]                         rcoarse_o,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]               ctrl_addr_offset,
   output logic                                        m_axi_awvalid,
   input  logic                                        m_axi_awready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]               m_axi_awaddr,
   output logic [7:0]                                  m_axi_awlen,
   output logic                                        m_axi_wvalid,
   input  logic                                        m_axi_wready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]               m_axi_wdata,
   output logic                                        m_axi_wlast,
   input  logic                                        m_axi_bvalid,
   output logic                                        m_axi_bready,
   input  logic [1:0]                                  m_axi_bresp
);
   localparam int CNT_W  = $clog2(N_BEATS) + 1;
   localparam int LB     = $clog2(BURST_LEN);
   localparam int RA_W   = $clog2(COARSE_DEPTH * BURST_LEN);
   localparam int NBURST = N_BEATS / BURST_LEN;
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES = C_M_AXI_ADDR_WIDTH'(BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_t;
   state_t r_state, w_next;

   logic [COARSE_W-1:0]           r_wc_s1, r_wc_s2, r_wc_bin, w_wc_bin, r_rcoarse, w_wb_next;
   logic [CNT_W-1:0]              r_aw_cnt, r_rd_beat, r_w_beat, r_b_cnt, w_rd_burst;
   logic                          r_awvalid, r_inflight, r_wr_ptr, r_rd_ptr;
   logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_buf [2];
   logic [1:0]                    r_cnt;
   logic                          w_start, w_aw_avail, w_rd_avail, w_w_hs, w_last_hs, w_b_hs, w_wlast, w_unused;

   always_comb begin
      w_wc_bin = '0;
      for (int k = 0; k < COARSE_W; k++) w_wc_bin[k] = ^(r_wc_s2 >> k);
   end

   assign w_start    = (r_state == S_IDLE) && start_i;
   assign w_rd_burst = r_rd_beat >> LB;
   // Each counter compares its own burst index against the producer pointer, modulo 2^COARSE_W
   assign w_aw_avail = r_wc_bin != COARSE_W'(r_aw_cnt);
   assign w_rd_avail = r_wc_bin != COARSE_W'(w_rd_burst);
   assign w_wlast    = (r_cnt != 2'd0) && ((r_w_beat & CNT_W'(BURST_LEN - 1)) == CNT_W'(BURST_LEN - 1));
   assign w_w_hs     = m_axi_wvalid & m_axi_wready;
   assign w_last_hs  = w_w_hs & w_wlast;
   assign w_b_hs     = m_axi_bvalid & m_axi_bready;
   assign w_wb_next  = COARSE_W'((r_w_beat + 1'b1) >> LB);

   // Occupancy counts the entry leaving this cycle, so the buffer sustains one beat per cycle without overflowing
   assign re_o = (r_state == S_BUSY) && (r_rd_beat < CNT_W'(N_BEATS)) && w_rd_avail && (w_rd_burst < r_aw_cnt)
                 && ((r_cnt + 2'(r_inflight) - 2'(w_w_hs)) < 2'd2);
   assign raddr_o       = RA_W'(r_rd_beat);
   assign rcoarse_o     = r_rcoarse;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awlen   = 8'(BURST_LEN - 1);
   assign m_axi_wvalid  = r_cnt != 2'd0;
   assign m_axi_wdata   = r_buf[r_rd_ptr];
   assign m_axi_wlast   = w_wlast;
   assign m_axi_bready  = (r_state == S_BUSY) || (r_state == S_DRAIN);
   assign done_o        = r_state == S_DONE;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start_i ? S_BUSY : S_IDLE;
         S_BUSY:  w_next = (w_w_hs && r_w_beat == CNT_W'(N_BEATS - 1)) ? S_DRAIN : S_BUSY;
         S_DRAIN: w_next = (r_b_cnt == CNT_W'(NBURST)) ? S_DONE : S_DRAIN;
         S_DONE:  w_next = release_i ? S_IDLE : S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wc_s1    <= '0;
         r_wc_s2    <= '0;
         r_wc_bin   <= '0;
         r_rcoarse  <= '0;
         r_aw_cnt   <= '0;
         r_rd_beat  <= '0;
         r_w_beat   <= '0;
         r_b_cnt    <= '0;
         r_awvalid  <= 1'b0;
         r_awaddr   <= '0;
         r_inflight <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_cnt      <= '0;
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
      end else begin
         r_wc_s1  <= wcoarse_i;
         r_wc_s2  <= r_wc_s1;
         r_wc_bin <= w_wc_bin;
         if (w_start) begin
            r_rcoarse  <= '0;
            r_aw_cnt   <= '0;
            r_rd_beat  <= '0;
            r_w_beat   <= '0;
            r_b_cnt    <= '0;
            r_awvalid  <= 1'b0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_cnt      <= '0;
         end else begin
            // Address is captured once per request so it stays stable under awready backpressure
            if (r_awvalid) begin
               if (m_axi_awready) begin
                  r_awvalid <= 1'b0;
                  r_aw_cnt  <= r_aw_cnt + 1'b1;
               end
            end else if (r_state == S_BUSY && r_aw_cnt < CNT_W'(NBURST) && w_aw_avail) begin
               r_awvalid <= 1'b1;
               r_awaddr  <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(r_aw_cnt) * BURST_BYTES;
            end
            if (re_o) r_rd_beat <= r_rd_beat + 1'b1;
            r_inflight <= re_o;
            if (r_inflight) begin
               r_buf[r_wr_ptr] <= rdata_i;
               r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_w_hs) begin
               r_rd_ptr <= ~r_rd_ptr;
               r_w_beat <= r_w_beat + 1'b1;
            end
            r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_w_hs);
            if (w_last_hs) r_rcoarse <= w_wb_next ^ (w_wb_next >> 1);
            if (w_b_hs) r_b_cnt <= r_b_cnt + 1'b1;
         end
      end
   end

`ifdef POINT_DMA_W_BRESP_CHECK_EN
   logic r_err;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_err <= 1'b0;
      else if (w_start) r_err <= 1'b0;
      else if (w_b_hs && m_axi_bresp != 2'b00) r_err <= 1'b1;
   end
   assign err_o    = r_err;
   assign w_unused = ^32'(ID);
`else
   assign err_o    = 1'b0;
   assign w_unused = ^{m_axi_bresp, 32'(ID)};
`endif
endmodule
